// File: rtl/parallel_txrx_fifo.sv
// Parallel host bus bridge with an RX FIFO (host -> fabric) and a TX FIFO (fabric -> host).
//
// The host owns chip_select and bus_strobe, both asynchronous to clock. A word transfers
// on each falling edge of bus_strobe. chip_select = 1 means the host writes and the word
// lands in the RX FIFO. chip_select = 0 means the bridge drives data_pins from tx_hold,
// and each strobe consumes the held word.
//
// Optional feature: define PARALLEL_TXRX_STATUS_EN to build the sticky rx_overflow and
// tx_underflow flags and their clear_flags input. Without it, both flags are tied low
// and clear_flags is ignored.
//
// Ports:
//   clock, reset             system clock; asynchronous active-high reset
//   chip_select, bus_strobe  asynchronous host controls
//   data_pins                shared bidirectional host bus
//   rx_data/rx_valid/rx_ready  RX FIFO head (valid/ready pop)
//   tx_data/tx_valid/tx_ready  TX FIFO input (valid/ready push)
//   clear_flags              clears the sticky flags
//   rx_overflow              sticky: a host write was dropped because the RX FIFO was full
//   tx_underflow             sticky: the host strobed a read while no word was held
module parallel_txrx_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             chip_select,
  input  logic             bus_strobe,
  inout  wire  [WIDTH-1:0] data_pins,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             clear_flags,
  output logic             rx_overflow,
  output logic             tx_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Synchronisers reset to 1 (bus idle), so no strobe event appears out of reset.
  logic [SYNC_STAGES-1:0] cs_sync_q, stb_sync_q;
  logic                   stb_prev_q;
  logic                   cs_s, stb_s, stb_evt;

  logic [WIDTH-1:0] rx_mem_q [DEPTH];
  logic [WIDTH-1:0] tx_mem_q [DEPTH];
  logic [PW-1:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [PW-1:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic             rx_empty, rx_full, tx_empty, tx_full;
  logic             rx_push_req, rx_push, rx_pop, rx_drop;
  logic             tx_push, hold_load, underflow_set;

  logic [WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             drive_en_q;

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign stb_s   = stb_sync_q[SYNC_STAGES-1];
  assign stb_evt = stb_prev_q & ~stb_s;

  // Full when the index bits match but the wrap bits differ.
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);

  // A push into a full FIFO still succeeds when the head is popped in the same cycle.
  assign rx_push_req = stb_evt & cs_s;
  assign rx_pop      = rx_ready & ~rx_empty;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign rx_drop     = rx_push_req & rx_full & ~rx_pop;

  assign tx_push       = tx_valid & ~tx_full;
  assign hold_load     = ~hold_valid_q & ~tx_empty;
  assign underflow_set = stb_evt & ~cs_s & ~hold_valid_q;

  always_comb begin
    rx_wptr_d    = rx_wptr_q;
    rx_rptr_d    = rx_rptr_q;
    tx_wptr_d    = tx_wptr_q;
    tx_rptr_d    = tx_rptr_q;
    tx_hold_d    = tx_hold_q;
    hold_valid_d = hold_valid_q;
    if (rx_push)   rx_wptr_d = rx_wptr_q + PW'(1);
    if (rx_pop)    rx_rptr_d = rx_rptr_q + PW'(1);
    if (tx_push)   tx_wptr_d = tx_wptr_q + PW'(1);
    if (hold_load) begin
      tx_rptr_d    = tx_rptr_q + PW'(1);
      tx_hold_d    = tx_mem_q[tx_rptr_q[AW-1:0]];
      hold_valid_d = 1'b1;
    end else if (stb_evt && !cs_s) begin
      // Host consumed the held word; the bus keeps showing it until the refill.
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_sync_q    <= '1;
      stb_sync_q   <= '1;
      stb_prev_q   <= 1'b1;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      tx_hold_q    <= '0;
      hold_valid_q <= 1'b0;
      drive_en_q   <= 1'b0;
    end else begin
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], chip_select};
      stb_sync_q   <= {stb_sync_q[SYNC_STAGES-2:0], bus_strobe};
      stb_prev_q   <= stb_s;
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      tx_wptr_q    <= tx_wptr_d;
      tx_rptr_q    <= tx_rptr_d;
      tx_hold_q    <= tx_hold_d;
      hold_valid_q <= hold_valid_d;
      drive_en_q   <= ~cs_s;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= data_pins;
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= tx_data;
  end

  assign data_pins = drive_en_q ? tx_hold_q : {WIDTH{1'bz}};
  assign rx_data   = rx_mem_q[rx_rptr_q[AW-1:0]];
  assign rx_valid  = ~rx_empty;
  assign tx_ready  = ~tx_full;

`ifdef PARALLEL_TXRX_STATUS_EN
  logic rx_overflow_q, tx_underflow_q;

  // A set condition in the same cycle as clear_flags wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
    end else begin
      if (rx_drop)          rx_overflow_q <= 1'b1;
      else if (clear_flags) rx_overflow_q <= 1'b0;
      if (underflow_set)    tx_underflow_q <= 1'b1;
      else if (clear_flags) tx_underflow_q <= 1'b0;
    end
  end

  assign rx_overflow  = rx_overflow_q;
  assign tx_underflow = tx_underflow_q;
`else
  logic unused_status;
  assign unused_status = ^{clear_flags, rx_drop, underflow_set};
  assign rx_overflow   = 1'b0;
  assign tx_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_txrx_fifo.sv
// Bench for parallel_txrx_fifo (WIDTH=8, DEPTH=16, SYNC_STAGES=2). A host model
// drives the shared bus. A pull-up on every bus bit makes an undriven bus read as 0xFF.
// Words expected on the RX side are queued as they are written. A monitor pops the
// queue and compares against each word the consumer takes.
module tb_parallel_txrx_fifo;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned SS = 2;
`ifdef PARALLEL_TXRX_STATUS_EN
  localparam logic StatusEn = 1'b1;
`else
  localparam logic StatusEn = 1'b0;
`endif
  localparam logic [W-1:0] BusZ = 8'hFF;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         chip_select = 1'b1;
  logic         bus_strobe = 1'b1;
  wire  [W-1:0] data_pins;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         clear_flags = 1'b0;
  logic         rx_overflow, tx_underflow;

  logic         host_oe = 1'b0;
  logic [W-1:0] host_data = '0;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] rx_exp [$];

  assign data_pins = host_oe ? host_data : {W{1'bz}};
  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup (data_pins[i]);
  end

  always #5 clock = ~clock;

  parallel_txrx_fifo #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS)) dut (
    .clock       (clock),
    .reset       (reset),
    .chip_select (chip_select),
    .bus_strobe  (bus_strobe),
    .data_pins   (data_pins),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .clear_flags (clear_flags),
    .rx_overflow (rx_overflow),
    .tx_underflow(tx_underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and stay stable through the next edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic host_write(input logic [W-1:0] v);
    host_data = v;
    host_oe   = 1'b1;
    tick(2);
    bus_strobe = 1'b0;
    tick(SS + 3);
    bus_strobe = 1'b1;
    tick(3);
  endtask

  task automatic host_read_strobe();
    bus_strobe = 1'b0;
    tick(SS + 3);
    bus_strobe = 1'b1;
    tick(4);
  endtask

  task automatic tx_push(input logic [W-1:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Sampled mid-cycle. rx_valid && rx_ready here means the head pops on the next edge.
  always @(negedge clock) begin
    if (!reset && rx_valid && rx_ready) begin
      checks++;
      if (rx_exp.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
      end else begin
        logic [W-1:0] e;
        e = rx_exp.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data: got 0x%0h, expected 0x%0h", rx_data, e);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_bus_z", 32'(data_pins), 32'(BusZ));
    check("rst_ovf", 32'(rx_overflow), 0);
    check("rst_udf", 32'(tx_underflow), 0);
    reset = 1'b0;
    tick(4);

    // Host writes drained straight through
    rx_ready = 1'b1;
    rx_exp.push_back(8'h11); host_write(8'h11);
    rx_exp.push_back(8'h22); host_write(8'h22);
    rx_exp.push_back(8'h33); host_write(8'h33);
    tick(3);
    check("wr_drained", 32'(rx_exp.size()), 0);
    check("wr_rx_valid", 32'(rx_valid), 0);

    // Overflow: 17 writes into 16 entries; the last one is dropped
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_exp.push_back(W'(i));
      host_write(W'(i));
    end
    check("ovf_rx_valid", 32'(rx_valid), 1);
    check("ovf_head", 32'(rx_data), 32'h00);
    check("ovf_flag", 32'(rx_overflow), 32'(StatusEn));
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("ovf_cleared", 32'(rx_overflow), 0);
    rx_ready = 1'b1;
    tick(20);
    check("ovf_drained", 32'(rx_exp.size()), 0);
    check("ovf_empty", 32'(rx_valid), 0);

    // Host read: two words, three strobes
    tx_push(8'hA5);
    tx_push(8'h5A);
    tick(2);
    host_oe     = 1'b0;
    chip_select = 1'b0;
    tick(SS + 3);
    check("rd_first", 32'(data_pins), 32'hA5);
    host_read_strobe();
    check("rd_second", 32'(data_pins), 32'h5A);
    check("rd_udf_0a", 32'(tx_underflow), 0);
    host_read_strobe();
    check("rd_hold_after_2", 32'(data_pins), 32'h5A);
    check("rd_udf_0b", 32'(tx_underflow), 0);
    host_read_strobe();
    check("rd_udf_set", 32'(tx_underflow), 32'(StatusEn));
    check("rd_bus_stays", 32'(data_pins), 32'h5A);

    // Turnaround: the bus is released whenever drive_en is low
    chip_select = 1'b1;
    tick(SS + 2);
    check("ta_z_cs1", 32'(data_pins), 32'(BusZ));
    chip_select = 1'b0;
    tick(1);
    check("ta_z_after1", 32'(data_pins), 32'(BusZ));
    tick(1);
    check("ta_z_after2", 32'(data_pins), 32'(BusZ));
    tick(1);
    check("ta_drive_after3", 32'(data_pins), 32'h5A);
    chip_select = 1'b1;
    tick(2);
    check("ta_still_driven", 32'(data_pins), 32'h5A);
    tick(1);
    check("ta_released", 32'(data_pins), 32'(BusZ));
    check("ta_udf_sticky", 32'(tx_underflow), 32'(StatusEn));

    // Reset mid-operation: words queued on both sides, TX filled to the brim
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) host_write(W'(8'h40 + i));
    host_oe = 1'b0;
    for (int i = 0; i < 17; i++) tx_push(W'(8'h80 + i));
    check("mid_rx_valid", 32'(rx_valid), 1);
    check("mid_tx_full", 32'(tx_ready), 0);
    reset = 1'b1;
    #1;
    check("mid_rst_rx_valid", 32'(rx_valid), 0);
    check("mid_rst_tx_ready", 32'(tx_ready), 1);
    check("mid_rst_bus_z", 32'(data_pins), 32'(BusZ));
    check("mid_rst_ovf", 32'(rx_overflow), 0);
    check("mid_rst_udf", 32'(tx_underflow), 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    check("post_rst_rx_valid", 32'(rx_valid), 0);
    chip_select = 1'b0;
    tick(SS + 4);
    // The TX queue was discarded, so the bus shows the reset value of tx_hold.
    check("post_rst_bus", 32'(data_pins), 32'h00);
    check("post_rst_udf", 32'(tx_underflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
